// File: rtl/ticket_pkg.sv
// Constants shared across the ticket machine: ON/OFF levels, bill acceptor
// default thresholds and the acceptor's one-hot state encodings.
package ticket_pkg;

    localparam logic On  = 1'b1;
    localparam logic Off = 1'b0;

    localparam int unsigned DefDebounce  = 4;
    localparam int unsigned DefLenW      = 8;
    localparam int unsigned DefTenMin    = 20;
    localparam int unsigned DefTenMax    = 40;
    localparam int unsigned DefTwentyMin = 60;
    localparam int unsigned DefTwentyMax = 80;
    localparam int unsigned DefJamLen    = 200;

    localparam logic [3:0] StDrain   = 4'b0001;
    localparam logic [3:0] StIdle    = 4'b0010;
    localparam logic [3:0] StMeasure = 4'b0100;
    localparam logic [3:0] StJam     = 4'b1000;

    function automatic logic in_window(int unsigned v, int unsigned lo, int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bill_debounce.sv
// Two-flop synchronizer followed by a mismatch-count debouncer for the
// optical bill sensor. Everything resets high so a bill present at reset is drained.
module bill_debounce
    import ticket_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DefDebounce
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic sense_i,
    output logic deb_o
);

    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

    logic            sync1_q, sync1_d;
    logic            s_q, s_d;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = sense_i;
        s_d     = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any agreeing cycle falls through with the counter cleared.
        if (s_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = s_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            sync1_q <= On;
            s_q     <= On;
            deb_q   <= On;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/bill_acceptor.sv
// Bill acceptor: measures how long each bill occludes the debounced sensor and
// emits a one-cycle Ten, Twenty or Reject pulse for the vending FSM.
module bill_acceptor
    import ticket_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = DefDebounce,
    parameter int unsigned LEN_W      = DefLenW,
    parameter int unsigned TEN_MIN    = DefTenMin,
    parameter int unsigned TEN_MAX    = DefTenMax,
    parameter int unsigned TWENTY_MIN = DefTwentyMin,
    parameter int unsigned TWENTY_MAX = DefTwentyMax,
    parameter int unsigned JAM_LEN    = DefJamLen
) (
    input  logic Clock,
    input  logic Clear,
    input  logic Sense,
    input  logic Ready,
    input  logic Bill,
    output logic Ten,
    output logic Twenty,
    output logic Reject,
    output logic Jam,
    output logic Busy
);

    localparam logic [LEN_W-1:0] JamLast = LEN_W'(JAM_LEN - 1);
    localparam logic [LEN_W-1:0] JamFull = LEN_W'(JAM_LEN);

    logic             deb;
    logic [3:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ten_q, ten_d;
    logic             twenty_q, twenty_d;
    logic             reject_q, reject_d;
    logic             acc;

    bill_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk_i   (Clock),
        .clear_i (Clear),
        .sense_i (Sense),
        .deb_o   (deb)
    );

    assign acc = Ready | Bill;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ten_d    = Off;
        twenty_d = Off;
        reject_d = Off;
        unique case (state_q)
            StDrain: begin
                if (!deb) state_d = StIdle;
            end
            StIdle: begin
                if (deb) begin
                    state_d = StMeasure;
                    len_d   = LEN_W'(1);
                end
            end
            StMeasure: begin
                if (!deb) begin
                    state_d = StIdle;
                    if (acc && in_window(32'(len_q), TEN_MIN, TEN_MAX)) begin
                        ten_d = On;
                    end else if (acc && in_window(32'(len_q), TWENTY_MIN, TWENTY_MAX)) begin
                        twenty_d = On;
                    end else begin
                        reject_d = On;
                    end
                end else if (len_q == JamLast) begin
                    // Entering JAM here is what keeps len from ever wrapping.
                    state_d = StJam;
                    len_d   = JamFull;
                end else begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            StJam: begin
                if (!deb) begin
                    state_d  = StIdle;
                    reject_d = On;
                end
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q  <= StDrain;
            len_q    <= '0;
            ten_q    <= Off;
            twenty_q <= Off;
            reject_q <= Off;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            ten_q    <= ten_d;
            twenty_q <= twenty_d;
            reject_q <= reject_d;
        end
    end

    assign Ten    = ten_q;
    assign Twenty = twenty_q;
    assign Reject = reject_q;
    assign Jam    = (state_q == StJam);
    assign Busy   = (state_q != StIdle);

endmodule

// File: tb/tb_bill_acceptor.sv
// Directed and randomized bench for bill_acceptor against a length-rule model.
module tb_bill_acceptor;

    localparam int Lag    = 6;
    localparam int Deb    = 4;
    localparam int JamLen = 200;

    localparam int OutNone   = 0;
    localparam int OutTen    = 1;
    localparam int OutTwenty = 2;
    localparam int OutReject = 3;

    logic clk = 1'b0;
    logic clear;
    logic sense;
    logic ready;
    logic bill;
    logic ten, twenty, reject, jam, busy;

    int checks = 0;
    int errors = 0;

    bill_acceptor u_dut (
        .Clock  (clk),
        .Clear  (clear),
        .Sense  (sense),
        .Ready  (ready),
        .Bill   (bill),
        .Ten    (ten),
        .Twenty (twenty),
        .Reject (reject),
        .Jam    (jam),
        .Busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_busy, input logic e_jam,
                              input int e_out);
        check({tag, " busy"}, busy, e_busy);
        check({tag, " jam"}, jam, e_jam);
        check({tag, " ten"}, ten, e_out == OutTen);
        check({tag, " twenty"}, twenty, e_out == OutTwenty);
        check({tag, " reject"}, reject, e_out == OutReject);
    endtask

    // Outcome from the bill-length rules alone.
    function automatic int outcome(input int n, input bit acc);
        if (n < Deb) return OutNone;
        if (n >= JamLen) return OutReject;
        if (acc && n >= 20 && n <= 40) return OutTen;
        if (acc && n >= 60 && n <= 80) return OutTwenty;
        return OutReject;
    endfunction

    // Sense high for n cycles; Ready/Bill are random except at the classify edge.
    task automatic run_bill(input int n, input bit rdy, input bit bil);
        int  out;
        bit  measured;
        bit  e_busy, e_jam;
        out      = outcome(n, rdy | bil);
        measured = (n >= Deb);
        sense    = 1'b1;
        ready    = 1'($urandom);
        bill     = 1'($urandom);
        for (int e = 1; e <= n + Lag + 4; e++) begin
            step;
            if (e == n) sense = 1'b0;
            if (e == n + Lag) begin
                ready = rdy;
                bill  = bil;
            end else begin
                ready = 1'($urandom);
                bill  = 1'($urandom);
            end
            e_busy = measured && (e >= Lag + 1) && (e < n + Lag + 1);
            e_jam  = (n >= JamLen) && (e >= Lag + JamLen) && (e < n + Lag + 1);
            check_outs($sformatf("bill n=%0d e=%0d", n, e), e_busy, e_jam,
                       (e == n + Lag + 1) ? out : OutNone);
        end
    endtask

    initial begin
        clear = 1'b1;
        sense = 1'b0;
        ready = 1'b0;
        bill  = 1'b0;

        // Reset behaviour
        step;
        check_outs("reset", 1'b1, 1'b0, OutNone);
        step;
        clear = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step;
            check_outs($sformatf("post-reset e=%0d", e), e < Lag + 1, 1'b0, OutNone);
        end

        // $10 window and edges
        run_bill(30, 1'b1, 1'b0);
        run_bill(20, 1'b1, 1'b0);
        run_bill(40, 1'b1, 1'b0);
        run_bill(19, 1'b1, 1'b0);
        run_bill(41, 1'b1, 1'b0);

        // $20 window, reject, glitch
        run_bill(60, 1'b0, 1'b1);
        run_bill(70, 1'b0, 1'b1);
        run_bill(80, 1'b0, 1'b1);
        run_bill(50, 1'b0, 1'b1);
        run_bill(3, 1'b0, 1'b1);

        // Not accepting, then accepting
        run_bill(30, 1'b0, 1'b0);
        run_bill(70, 1'b1, 1'b0);

        // Jam
        run_bill(250, 1'b1, 1'b1);

        // Clear while measuring: len reaches 25 at edge 31
        sense = 1'b1;
        for (int e = 1; e <= 52; e++) begin
            step;
            clear = (e == 31);
            if (e == 40) sense = 1'b0;
            check_outs($sformatf("clear-mid e=%0d", e), (e >= Lag + 1) && (e < 40 + Lag + 1),
                       1'b0, OutNone);
        end
        run_bill(30, 1'b1, 1'b0);

        // Randomized bills
        for (int i = 0; i < 16; i++) begin
            run_bill(int'($urandom_range(1, 110)), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bill_acceptor.md
# bill_acceptor

Front-end stage of the ticket machine: it conditions the raw optical bill sensor and classifies each inserted bill by how long it takes to pass the sensor. It drives the one-cycle `Ten` / `Twenty` pulses consumed directly by the ticket vending FSM. Invalid bills, bills inserted while the FSM is not accepting, and jams produce a `Reject` pulse instead of a credit.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive synchronized cycles a new sensor level must hold before it is accepted.
- `LEN_W`, default 8: width of the length counter.
- `TEN_MIN` / `TEN_MAX`, defaults 20 / 40: inclusive length window (cycles) for a $10 bill.
- `TWENTY_MIN` / `TWENTY_MAX`, defaults 60 / 80: inclusive length window for a $20 bill.
- `JAM_LEN`, default 200: length at which a bill is declared jammed.
- Legal settings require `TEN_MAX < TWENTY_MIN`, `TWENTY_MAX < JAM_LEN < 2**LEN_W`, and `DEBOUNCE >= 1`.

Ports:
- `Clock` in 1: the single clock. All state updates on its rising edge.
- `Clear` in 1: synchronous, active-high reset.
- `Sense` in 1: raw, asynchronous sensor input. High while a bill occludes the sensor.
- `Ready` in 1: from the vending FSM.
- `Bill` in 1: from the vending FSM.
- `Ten` out 1: one-cycle pulse crediting $10.
- `Twenty` out 1: one-cycle pulse crediting $20.
- `Reject` out 1: one-cycle pulse meaning the bill is returned to the customer.
- `Jam` out 1: level output, high while a jam is in progress.
- `Busy` out 1: level output, high whenever the FSM is not in IDLE.

## Operation
Sensor conditioning:
- `Sense` passes through a 2-flop synchronizer to produce `s`.
- The debounced level `deb` changes to the value of `s` only after `s` has differed from `deb` for `DEBOUNCE` consecutive cycles. Each agreeing cycle zeroes the mismatch counter.
- The total edge lag from `Sense` to `deb` is L = `DEBOUNCE`+2 cycles (6 at the default setting).
- Any `Sense` glitch shorter than `DEBOUNCE` cycles is invisible downstream.

State machine (one-hot, four states):
- DRAIN (reset state):
  - wait for `deb`=0, then go to IDLE.
  - No pulses are emitted in this state.
- IDLE:
  - `deb`=1 → MEASURE, with `len`=1.
- MEASURE:
  - While `deb`=1: `len`++ each cycle.
  - When `len` reaches `JAM_LEN` → JAM and set `Jam`=1.
  - When `deb`=0 → IDLE. At the same edge, classify `len` and sample `acc` = `Ready`|`Bill`:
    - If `acc`=1 and `len` is in [`TEN_MIN`,`TEN_MAX`]: register `Ten`=1.
    - If `acc`=1 and `len` is in [`TWENTY_MIN`,`TWENTY_MAX`]: register `Twenty`=1.
    - Otherwise: register `Reject`=1.
- JAM:
  - When `deb`=0 → IDLE, `Jam`=0, `Reject`=1.

Invariants:
- At most one of `Ten`, `Twenty` and `Reject` is high in any cycle.
- Every bill that reaches MEASURE produces exactly one pulse.
- `len` saturates and never wraps, because JAM is entered first.

## Timing
- Reset values:
  - all outputs 0 except `Busy`=1;
  - `deb`=1 and synchronizer flops 1;
  - state DRAIN, `len`=0.
- Because reset forces `deb`=1, a bill already under the sensor at `Clear` is drained without credit.
- With `Sense` low, `Busy` falls L+1 cycles after `Clear` deasserts.
- Bill latency:
  - a `Sense` high pulse of N cycles yields `len`=N;
  - the outcome pulse is high for exactly one cycle, L+1 cycles after `Sense` falls;
  - `Busy` falls in the same cycle the pulse rises.
- `Jam` rises L+`JAM_LEN` cycles after `Sense` rises.
- `Ready`/`Bill` are sampled only at the classify edge. Their value at any other time is irrelevant.
- A back-to-back bill (`Sense` rising again during the lag) is handled normally. The two pulses are separated by at least `DEBOUNCE` cycles, which suits the vending FSM's one-state-per-cycle advance.
- `Clear` mid-MEASURE or mid-JAM:
  - state returns to DRAIN the next cycle;
  - `Jam` drops and no pulse is emitted for that bill.

## Structure
- Shared package `ticket_pkg` holds:
  - the one-hot state encodings for this block;
  - default threshold constants;
  - the ON/OFF constants used across the ticket machine.
- Sub-module `bill_debounce` contains the synchronizer plus the mismatch counter and outputs `deb`.
- The top level holds the FSM, the length counter, classification and the output registers.
- Target size is roughly 150–250 lines of RTL.

## Test plan
All scenarios use default parameters.
1. Reset behaviour: `Clear` 2 cycles, `Sense`=0 → `Busy` drops 7 cycles after `Clear` deasserts; no `Ten`/`Twenty`/`Reject` pulse at any point.
2. $10 bill and window edges: `Ready`=1, `Sense` high 30 cycles → single `Ten` pulse 7 cycles after `Sense` falls. Repeat with lengths 20 and 40 (`Ten`) and with 19 and 41 (`Reject`).
3. $20 bill and rejects: `Bill`=1, `Sense` high 60, 70 and 80 → `Twenty` each time; length 50 → `Reject`; a 3-cycle `Sense` glitch → no pulse and `Busy` stays 0.
4. Not accepting: `Ready`=`Bill`=0, `Sense` high 30 → `Reject` only. Then `Ready`=1, `Sense` high 70 → `Twenty`.
5. Jam: `Sense` high 250 → `Jam` rises 206 cycles after `Sense` rises and stays high until the drain; then `Reject` pulses 7 cycles after `Sense` falls and `Jam` returns to 0.
6. `Clear` mid-bill: `Sense` high 40, `Clear` asserted at `len`=25 while `Sense` stays high → no pulse, `Busy`=1 until `Sense` has been low for 7 cycles; a following 30-cycle bill → `Ten`.
